// File: rtl/spi_readout_ctrl.sv
// SPI mode-0 slave that streams capture-readout memory bytes out on MISO and collects MOSI bytes.
// Define SPI_READOUT_CRC_EN to append a CRC-8 (poly 0x07) byte after the payload.
module spi_readout_ctrl #(
  parameter int NUM_BYTES   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       mem_reset_addr,
  output logic       mem_incr,
  input  logic [7:0] mem_byte,
  output logic       snap_req,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       overrun
);

  // Headroom so byte_cnt + 1 never wraps, even at the saturated limit.
  localparam int CW = $clog2(NUM_BYTES + 3);
  localparam logic [CW-1:0] NB = CW'(NUM_BYTES);
`ifdef SPI_READOUT_CRC_EN
  localparam logic [CW-1:0] LIMIT = CW'(NUM_BYTES + 1);
`else
  localparam logic [CW-1:0] LIMIT = CW'(NUM_BYTES);
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_d, cs_d;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  logic [7:0]    shift_reg, rx_shift;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] byte_cnt, byte_nxt;
  logic [1:0]    incr_cnt;
  logic          ld_wait, cs_pend, start;
`ifdef SPI_READOUT_CRC_EN
  logic [7:0]    crc;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
`endif

  // cs_n idles high, so its chain presets to 1 to avoid a false cs_fall out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign byte_nxt = byte_cnt + 1'b1;
  assign mem_incr = (incr_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE:    if ((cs_fall || cs_pend) && !mem_incr) begin
                 start     = 1'b1;
                 state_nxt = LOAD;
               end
      LOAD:    if (ld_wait) state_nxt = SHIFT;
      SHIFT:   state_nxt = SHIFT;
      default: state_nxt = IDLE;
    endcase
    if (cs_rise) begin
      start     = 1'b0;
      state_nxt = IDLE;
    end
  end

  assign snap_req       = start;
  assign mem_reset_addr = start;
  assign busy           = (state != IDLE);
  assign miso           = (state == SHIFT) && shift_reg[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      rx_shift    <= '0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      incr_cnt    <= '0;
      ld_wait     <= 1'b0;
      cs_pend     <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      overrun     <= 1'b0;
`ifdef SPI_READOUT_CRC_EN
      crc         <= '0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      // An increment pulse always runs its full two cycles, even across cs_rise.
      if (incr_cnt != 2'd0) incr_cnt <= incr_cnt - 2'd1;
      if (start) begin
        overrun <= 1'b0;
        cs_pend <= 1'b0;
        ld_wait <= 1'b0;
      end else if (state == IDLE && cs_fall) begin
        cs_pend <= 1'b1;
      end
      if (cs_rise) begin
        frame_done  <= 1'b1;
        frame_abort <= (bit_cnt != 4'd0) || (state == LOAD);
        bit_cnt     <= '0;
        cs_pend     <= 1'b0;
      end else if (state == LOAD) begin
        ld_wait <= 1'b1;
        if (ld_wait) begin
          shift_reg <= mem_byte;
          bit_cnt   <= '0;
          byte_cnt  <= '0;
`ifdef SPI_READOUT_CRC_EN
          crc       <= crc8(8'h00, mem_byte);
`endif
        end
      end else if (state == SHIFT) begin
        if (sck_rise) begin
          if (byte_cnt >= LIMIT) overrun <= 1'b1;
          rx_shift <= {rx_shift[6:0], mosi_s};
          if (bit_cnt == 4'd7) begin
            bit_cnt  <= 4'd8;
            rx_byte  <= {rx_shift[6:0], mosi_s};
            rx_valid <= 1'b1;
            if (byte_cnt < LIMIT) byte_cnt <= byte_nxt;
            if (byte_nxt < NB) incr_cnt <= 2'd2;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else if (sck_fall && bit_cnt == 4'd8) begin
          bit_cnt <= '0;
          if (byte_cnt < NB) begin
            shift_reg <= mem_byte;
`ifdef SPI_READOUT_CRC_EN
            crc       <= crc8(crc, mem_byte);
`endif
          end
`ifdef SPI_READOUT_CRC_EN
          else if (byte_cnt == NB) shift_reg <= crc;
`endif
          else shift_reg <= 8'h00;
        end else if (sck_fall && bit_cnt != 4'd0) begin
          shift_reg <= {shift_reg[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_readout_ctrl.sv
// Randomized bench for spi_readout_ctrl: host SPI driver, readout memory model, frame-level reference.
module tb_spi_readout_ctrl;
  localparam int N    = 8;
  localparam int HALF = 8;
`ifdef SPI_READOUT_CRC_EN
  localparam int LIM = N + 1;
  localparam bit CRC = 1'b1;
`else
  localparam int LIM = N;
  localparam bit CRC = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, mem_reset_addr, mem_incr, snap_req, rx_valid, busy, frame_done, frame_abort, overrun;
  logic [7:0] rx_byte;
  logic [7:0] mem_byte = 8'h00;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  spi_readout_ctrl #(.NUM_BYTES(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .mem_reset_addr(mem_reset_addr), .mem_incr(mem_incr), .mem_byte(mem_byte),
    .snap_req(snap_req), .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy),
    .frame_done(frame_done), .frame_abort(frame_abort), .overrun(overrun)
  );

  // Readout memory: address acts on reset strobe / mem_incr rising edge; data lags one clk.
  logic [7:0] mem_arr [N];
  int addr = 0, max_addr = 0;
  logic incr_d = 1'b0;
  always @(posedge clk) begin
    if (mem_reset_addr) addr <= 0;
    else if (mem_incr && !incr_d) addr <= addr + 1;
    incr_d   <= mem_incr;
    mem_byte <= (addr < N) ? mem_arr[addr] : 8'hEE;
  end

  // Event counters sampled 1 time unit after each active edge.
  int n_incr, n_rst, n_snap, n_done, n_abort;
  logic [7:0] rx_q [$];
  logic mi_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mem_incr && !mi_prev) n_incr++;
    mi_prev = mem_incr;
    if (mem_reset_addr) n_rst++;
    if (snap_req) n_snap++;
    if (frame_done) n_done++;
    if (frame_abort) n_abort++;
    if (rx_valid) rx_q.push_back(rx_byte);
    if (addr > max_addr) max_addr = addr;
  end

  logic [7:0] tx [16];
  logic [7:0] mb [16];
  bit ov_pre [128];
  logic busy_mid;

  function automatic logic [7:0] crc_model();
    logic [7:0] c = 8'h00;
    logic fb;
    for (int i = 0; i < N; i++)
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ mem_arr[i][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return c;
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    if (i < N) return mem_arr[i];
    if (CRC && i == N) return crc_model();
    return 8'h00;
  endfunction

  task automatic clear_mon();
    n_incr = 0; n_rst = 0; n_snap = 0; n_done = 0; n_abort = 0;
    rx_q.delete();
    max_addr = 0;
  endtask

  // Host side: mode 0, sample MISO just before each rising edge.
  task automatic run_frame(input int nbits, input bit do_end);
    @(negedge clk);
    clear_mon();
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
    busy_mid = busy;
    for (int k = 0; k < nbits; k++) begin
      mosi = tx[k / 8][7 - (k % 8)];
      repeat (HALF) @(negedge clk);
      mb[k / 8][7 - (k % 8)] = miso;
      ov_pre[k] = overrun;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    if (do_end) begin
      cs_n = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic fill_mem_a0();
    for (int i = 0; i < N; i++) mem_arr[i] = 8'hA0 + 8'(i);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({miso, mem_reset_addr, mem_incr, snap_req, rx_valid, busy, frame_done, frame_abort, overrun, rx_byte} !== 17'h0) begin
      errs++; $display("FAIL reset_outputs: got busy=%b incr=%b rx_byte=%h want all 0", busy, mem_incr, rx_byte);
    end
    rst_n = 1'b1;
    clear_mon();
    repeat (10) @(negedge clk);
    checks++;
    if (n_snap !== 0 || busy !== 1'b0) begin
      errs++; $display("FAIL reset_idle: got snaps=%0d busy=%b want 0 0", n_snap, busy);
    end
  endtask

  task automatic test_basic();
    fill_mem_a0();
    for (int i = 0; i < 16; i++) tx[i] = 8'h5A;
    run_frame(8 * N, 1'b1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mb[i] !== exp_byte(i)) begin
        errs++; $display("FAIL basic_miso[%0d]: got %h want %h", i, mb[i], exp_byte(i));
      end
    end
    checks++;
    if (n_incr !== N - 1 || n_rst !== 1 || n_snap !== 1) begin
      errs++; $display("FAIL basic_strobes: got incr=%0d rst=%0d snap=%0d want %0d 1 1", n_incr, n_rst, n_snap, N - 1);
    end
    checks++;
    if (rx_q.size() !== N) begin
      errs++; $display("FAIL basic_rx_count: got %0d want %0d", rx_q.size(), N);
    end
    foreach (rx_q[i]) begin
      checks++;
      if (rx_q[i] !== 8'h5A) begin
        errs++; $display("FAIL basic_rx[%0d]: got %h want 5a", i, rx_q[i]);
      end
    end
    checks++;
    if (n_done !== 1 || n_abort !== 0 || overrun !== 1'b0 || busy_mid !== 1'b1) begin
      errs++; $display("FAIL basic_status: got done=%0d abort=%0d ovr=%b busy=%b want 1 0 0 1", n_done, n_abort, overrun, busy_mid);
    end
  endtask

  task automatic test_overrun();
    fill_mem_a0();
    for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
    run_frame(8 * (N + 2), 1'b1);
    for (int i = N; i < N + 2; i++) begin
      checks++;
      if (mb[i] !== exp_byte(i)) begin
        errs++; $display("FAIL ovr_tail_miso[%0d]: got %h want %h", i, mb[i], exp_byte(i));
      end
    end
    checks++;
    if (n_incr !== N - 1 || max_addr > N - 1) begin
      errs++; $display("FAIL ovr_incr: got incr=%0d max_addr=%0d want %0d <=%0d", n_incr, max_addr, N - 1, N - 1);
    end
    checks++;
    if (ov_pre[8 * LIM] !== 1'b0 || ov_pre[8 * LIM + 1] !== 1'b1) begin
      errs++; $display("FAIL ovr_timing: got before=%b after=%b want 0 1", ov_pre[8 * LIM], ov_pre[8 * LIM + 1]);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errs++; $display("FAIL ovr_sticky: got %b want 1", overrun);
    end
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errs++; $display("FAIL ovr_clear: got %b want 0", overrun);
    end
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    fill_mem_a0();
    run_frame(2 * 8 + 3, 1'b0);
    cs_n = 1'b1;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        checks++;
        if (frame_abort !== 1'b1 || miso !== 1'b0 || busy !== 1'b0) begin
          errs++; $display("FAIL abort_pulse: got abort=%b miso=%b busy=%b want 1 0 0", frame_abort, miso, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
          errs++; $display("FAIL abort_after: got busy=%b done=%b want 0 0", busy, frame_done);
        end
      end
    end
    checks++;
    if (!seen) begin
      errs++; $display("FAIL abort_timeout: got no frame_done want one within 20 clk");
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_collision();
    fill_mem_a0();
    for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
    run_frame(15, 1'b0);
    sck  = 1'b1;
    cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (rx_q.size() !== 1 || n_done !== 1 || n_abort !== 1 || busy !== 1'b0) begin
      errs++; $display("FAIL collision: got rx=%0d done=%0d abort=%0d busy=%b want 1 1 1 0", rx_q.size(), n_done, n_abort, busy);
    end
  endtask

  task automatic test_reset_mid();
    fill_mem_a0();
    for (int i = 0; i < 16; i++) tx[i] = 8'h80 | 8'($urandom);
    run_frame(4 * 8 + 3, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({miso, mem_reset_addr, mem_incr, snap_req, rx_valid, busy, frame_done, frame_abort, overrun, rx_byte} !== 17'h0) begin
      errs++; $display("FAIL rst_async: got busy=%b rx_byte=%h miso=%b want all 0", busy, rx_byte, miso);
    end
    cs_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_done !== 0) begin
      errs++; $display("FAIL rst_no_done: got %0d want 0", n_done);
    end
    run_frame(8, 1'b1);
    checks++;
    if (mb[0] !== 8'hA0 || n_rst !== 1) begin
      errs++; $display("FAIL rst_restart: got %h rst=%0d want a0 1", mb[0], n_rst);
    end
  endtask

`ifdef SPI_READOUT_CRC_EN
  task automatic test_crc();
    for (int i = 0; i < N; i++) mem_arr[i] = 8'(i + 1);
    for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
    run_frame(8 * (N + 1), 1'b1);
    checks++;
    if (mb[N] !== crc_model()) begin
      errs++; $display("FAIL crc_byte: got %h want %h", mb[N], crc_model());
    end
    checks++;
    if (overrun !== 1'b0 || n_incr !== N - 1) begin
      errs++; $display("FAIL crc_status: got ovr=%b incr=%0d want 0 %0d", overrun, n_incr, N - 1);
    end
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int nb;
      nb = int'($urandom_range(1, N + 2));
      for (int i = 0; i < N; i++) mem_arr[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
      run_frame(8 * nb, 1'b1);
      for (int i = 0; i < nb; i++) begin
        checks++;
        if (mb[i] !== exp_byte(i)) begin
          errs++; $display("FAIL rand%0d_miso[%0d]: got %h want %h", it, i, mb[i], exp_byte(i));
        end
      end
      checks++;
      if (rx_q.size() !== nb) begin
        errs++; $display("FAIL rand%0d_rx_count: got %0d want %0d", it, rx_q.size(), nb);
      end
      foreach (rx_q[i]) begin
        checks++;
        if (i < nb && rx_q[i] !== tx[i]) begin
          errs++; $display("FAIL rand%0d_rx[%0d]: got %h want %h", it, i, rx_q[i], tx[i]);
        end
      end
      checks++;
      if (n_incr !== ((nb < N - 1) ? nb : N - 1) || max_addr > N - 1) begin
        errs++; $display("FAIL rand%0d_incr: got %0d max_addr=%0d", it, n_incr, max_addr);
      end
      checks++;
      if (overrun !== (nb > LIM) || n_done !== 1 || n_abort !== 0) begin
        errs++; $display("FAIL rand%0d_status: got ovr=%b done=%0d abort=%0d want %b 1 0", it, overrun, n_done, n_abort, nb > LIM);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_abort();
    test_collision();
    test_reset_mid();
`ifdef SPI_READOUT_CRC_EN
    test_crc();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/spi_readout_ctrl.md
Name: spi_readout_ctrl

Overview:
- SPI-slave sequencer for the capture readout memory: drives that memory's address-reset and increment strobes, loads each returned byte into a shift register and clocks it out MSB-first on MISO.
- SPI mode 0; sck, cs_n and mosi are asynchronous to clk and are synchronised inside this block.
- Issues a one-cycle snapshot request at frame start so the capture logic freezes F/C/L/R for the whole frame.
- Captures MOSI bytes for a host command path.

Parameters:
- NUM_BYTES, 8: payload bytes per frame; memory address range 0..NUM_BYTES-1.
- SYNC_STAGES, 2: flip-flop depth of the sck/cs_n/mosi synchronisers, minimum 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock, asynchronous to clk.
- cs_n  in  1  SPI chip select, active-low, asynchronous.
- mosi  in  1  SPI data from host.
- miso  out  1  SPI data to host.
- mem_reset_addr  out  1  one-cycle pulse; resets the memory address to 0.
- mem_incr  out  1  strobe that advances the memory address (memory acts on its rising edge).
- mem_byte  in  8  byte at the current memory address, valid 1 clk after an address change.
- snap_req  out  1  one-cycle pulse at frame start.
- rx_byte  out  8  last complete MOSI byte.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse on cs_n deassert.
- frame_abort  out  1  one-cycle pulse, coincident with frame_done, when the frame ended mid-byte.
- overrun  out  1  sticky flag; host clocked past the last valid byte.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0; state IDLE; shift register, bit counter and byte counter 0.
  - cs_n synchroniser presets to 1 (inactive); sck and mosi synchronisers to 0.
- Edge detection: on synchronised signals. sck_rise, sck_fall, cs_fall and cs_rise are each one-cycle events.
- Timing requirement: each SCK half-period is at least 6 clk cycles. Behaviour is undefined below this.
- State IDLE:
  - miso = 0; busy = 0.
  - On cs_fall: pulse snap_req and mem_reset_addr in the same cycle, then go to LOAD.
- State LOAD (2 clk):
  - Wait 1 cycle for the address reset to take effect.
  - Load shift register from mem_byte; bit_cnt = 0; byte_cnt = 0; go to SHIFT.
  - busy = 1 from the cycle after cs_fall.
- State SHIFT:
  - miso = shift_reg[7] at all times.
  - sck_rise: shift mosi into the rx shift register; bit_cnt increments.
  - 8th sck_rise of a byte:
    - rx_byte updates and rx_valid pulses.
    - byte_cnt increments.
    - If byte_cnt (new value) < NUM_BYTES, raise mem_incr for 2 clk, then low.
  - sck_fall after a non-final bit: shift_reg shifts left by 1, inserting 0.
  - sck_fall after the 8th bit: bit_cnt = 0 and shift_reg reloads.
    - If byte_cnt < NUM_BYTES: reload from mem_byte (address has already advanced).
    - Otherwise: reload with 0x00 (or CRC, see Optional Feature).
- Overrun: an sck_rise when byte_cnt ≥ NUM_BYTES (NUM_BYTES+1 with CRC) sets overrun. It clears only on the next cs_fall.
- mem_incr is never asserted when byte_cnt ≥ NUM_BYTES. The memory address therefore never exceeds NUM_BYTES-1 and cannot wrap.
- cs_rise in any state:
  - Return to IDLE and drop miso to 0.
  - Pulse frame_done.
  - Also pulse frame_abort if bit_cnt ≠ 0 or the state is LOAD.
  - A mem_incr in progress completes its 2-cycle pulse; no new pulse is started.
- Simultaneous events:
  - cs_rise takes priority over any sck edge in the same cycle.
  - A cs_fall arriving while IDLE with the mem_incr tail still active waits until mem_incr is low.
- cs_n held low with no sck: state holds indefinitely; no timeout.
- Reset mid-frame: immediate return to IDLE; no frame_done pulse.

Optional Feature:
- Macro: SPI_READOUT_CRC_EN.
- Defined:
  - A CRC-8 (poly 0x07, init 0x00, MSB-first) accumulates every payload byte as it is loaded into shift_reg.
  - Byte index NUM_BYTES transmits the CRC.
  - The overrun threshold becomes NUM_BYTES+1.
- Undefined: no CRC logic; index NUM_BYTES onward transmits 0x00.

Test Plan:
- Memory model returns 0xA0+addr. Assert cs_n, clock 8 bytes of mosi 0x5A at sck=8 clk/half. Required response:
  - miso stream A0..A7.
  - Exactly 7 mem_incr pulses and 1 mem_reset_addr.
  - 8 rx_valid pulses, each with rx_byte=0x5A.
  - frame_done=1, frame_abort=0, overrun=0.
- Same frame, clocking 10 bytes: bytes 8–9 read 0x00 (CRC_EN undefined), overrun=1 after the 9th byte's first sck_rise, still 7 mem_incr. Next cs_fall clears overrun.
- Deassert cs_n after 3 bits of byte 2: frame_done and frame_abort pulse together, busy=0 next cycle, miso=0.
- With SPI_READOUT_CRC_EN defined, memory bytes 0x01..0x08, 9 bytes clocked: byte 8 equals the CRC-8/0x07 of 01..08, computed by the bench model.
- rst_n pulsed low mid-byte 4: all outputs 0 asynchronously, no frame_done. A new frame afterwards starts at address 0 and reads A0.
- cs_rise and sck_rise in the same clk: no rx_valid, frame_done pulses, state is IDLE.
